// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, instruction memory and decode.
// The master modport is the fetch controller's view; slave is the environment's.
interface fetch_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_redirect_valid_in;
    logic [XLEN-1:0] fetch_redirect_addr_in;
    logic            ins_mem_valid_out;
    logic [XLEN-1:0] ins_mem_addr_out;
    logic            ins_mem_ready_in;
    logic [XLEN-1:0] ins_mem_data_in;
    logic            ins_valid_out;
    logic [XLEN-1:0] ins_data_out;
    logic [XLEN-1:0] ins_pc_out;
    logic            ins_ready_in;
    logic            fetch_error_out;

    modport master (
        input  fetch_redirect_valid_in,
        input  fetch_redirect_addr_in,
        output ins_mem_valid_out,
        output ins_mem_addr_out,
        input  ins_mem_ready_in,
        input  ins_mem_data_in,
        output ins_valid_out,
        output ins_data_out,
        output ins_pc_out,
        input  ins_ready_in,
        output fetch_error_out
    );

    modport slave (
        output fetch_redirect_valid_in,
        output fetch_redirect_addr_in,
        input  ins_mem_valid_out,
        input  ins_mem_addr_out,
        output ins_mem_ready_in,
        output ins_mem_data_in,
        input  ins_valid_out,
        input  ins_data_out,
        input  ins_pc_out,
        output ins_ready_in,
        input  fetch_error_out
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues word requests to instruction
// memory and buffers returned words with their PC in a 2-entry queue toward decode.
module fetch_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input logic          clock_in,
    input logic          reset_in,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFull,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      count_q, count_d;
    logic [XLEN-1:0] q_pc_q   [2];
    logic [XLEN-1:0] q_pc_d   [2];
    logic [XLEN-1:0] q_data_q [2];
    logic [XLEN-1:0] q_data_d [2];

    logic xfer;
    logic pop;
    logic wr_sel;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        q_pc_d[0]   = q_pc_q[0];
        q_pc_d[1]   = q_pc_q[1];
        q_data_d[0] = q_data_q[0];
        q_data_d[1] = q_data_q[1];

        xfer   = (state_q == StFetch) && bus.ins_mem_ready_in && !bus.fetch_redirect_valid_in;
        pop    = (count_q != 2'd0) && bus.ins_ready_in;
        // Tail slot for a push, taking a simultaneous pop's shift into account.
        wr_sel = pop ? (count_q == 2'd2) : (count_q == 2'd1);

        if (bus.fetch_redirect_valid_in) begin
            count_d = 2'd0;
            pc_d    = bus.fetch_redirect_addr_in;
            state_d = (bus.fetch_redirect_addr_in[1:0] != 2'b00) ? StError : StFetch;
        end else begin
            if (pop) begin
                q_pc_d[0]   = q_pc_q[1];
                q_data_d[0] = q_data_q[1];
            end
            if (xfer) begin
                q_pc_d[wr_sel]   = pc_q;
                q_data_d[wr_sel] = bus.ins_mem_data_in;
                pc_d             = pc_q + XLEN'(4);
            end
            count_d = count_q + {1'b0, xfer} - {1'b0, pop};

            unique case (state_q)
                StIdle:  state_d = (RESET_VECTOR[1:0] != 2'b00) ? StError : StFetch;
                StFetch: state_d = (count_d == 2'd2) ? StFull : StFetch;
                StFull:  state_d = (count_d < 2'd2) ? StFetch : StFull;
                StError: state_d = StError;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= StIdle;
            pc_q        <= RESET_VECTOR;
            count_q     <= 2'd0;
            q_pc_q[0]   <= '0;
            q_pc_q[1]   <= '0;
            q_data_q[0] <= '0;
            q_data_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            q_pc_q[0]   <= q_pc_d[0];
            q_pc_q[1]   <= q_pc_d[1];
            q_data_q[0] <= q_data_d[0];
            q_data_q[1] <= q_data_d[1];
        end
    end

    // All outputs come straight from registers; no input-to-output paths.
    assign bus.ins_mem_valid_out = (state_q == StFetch);
    assign bus.ins_mem_addr_out  = pc_q;
    assign bus.ins_valid_out     = (count_q != 2'd0);
    assign bus.ins_data_out      = q_data_q[0];
    assign bus.ins_pc_out        = q_pc_q[0];
    assign bus.fetch_error_out   = (state_q == StError);

endmodule
